snap_ram_writer: RTL and testbench
==================================

Name: snap_ram_writer

Overview:
- Write-buffer stage directly downstream of the snapshot loader.
- Accepts byte writes (25-bit address, 8-bit data, 1-cycle strobe) from the loader and queues them in a small FIFO.
- Drains the FIFO to the shared SDRAM write port over a req/ack handshake.
- Generates the ram_ready back-pressure the loader uses to pace RLE run expansion.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 4.
- AW, 25, address width.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- in_addr  in  AW  write address from loader
- in_data  in  8  write data from loader
- in_wr  in  1  one-cycle write strobe; address and data are sampled only in this cycle
- ram_ready  out  1  high when the FIFO can absorb at least 2 more writes
- mem_addr  out  AW  address presented to SDRAM
- mem_din  out  8  data presented to SDRAM
- mem_req  out  1  write request; level, held until ack
- mem_ack  in  1  one-cycle completion pulse from SDRAM controller
- busy  out  1  FIFO non-empty or request outstanding
- overflow  out  1  sticky flag: a write arrived while the FIFO was full

Behaviour:
- Clock and reset: clk_sys only; reset is synchronous and active-high.
- Reset values: ram_ready=1, mem_req=0, mem_addr=0, mem_din=0, busy=0, overflow=0.
- Reset clears pointers and count, and the FSM goes to IDLE.
- Reset mid-request: mem_req=0 on the next edge. Queued data is discarded.
- FIFO storage: {addr, data} entries with read/write pointers of log2(DEPTH) bits, wrapping naturally. The count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push: in_wr && count<DEPTH writes the entry at wptr and increments wptr.
- Push when full: in_wr && count==DEPTH drops the write, sets overflow (cleared only by reset), and leaves state unchanged.
- Pop: occurs only on mem_ack while in REQ.
- Push and pop in the same cycle: count unchanged and both pointers advance. This is legal even at count==DEPTH, because the pop frees the slot first.
- ram_ready is registered and equals (next_count <= DEPTH-2). It therefore reflects this cycle's push/pop with 1-cycle latency.
- FSM has 3 states:
  - IDLE: if count!=0, latch the head entry into mem_addr/mem_din, set mem_req=1, and go to REQ.
  - REQ: mem_req=1 and mem_addr/mem_din are held stable. On mem_ack: pop, mem_req=0, go to GAP.
  - GAP: one cycle with mem_req=0 (the controller needs a deasserted edge). Then behaves as IDLE: if count!=0 (after the pop), latch the new head and go to REQ; else go to IDLE.
- Minimum spacing between back-to-back requests: ack at cycle N, mem_req low at N+1, next mem_req high at N+2. Sustained throughput is 1 write per (ack latency + 2) cycles.
- mem_ack outside REQ is ignored: no pop, no state change.
- Entry latency: a write pushed into an empty FIFO in IDLE at cycle N has mem_req=1 at N+2 (count visible at N+1, latched at N+2).
- busy is registered as (next_count!=0) || next_state==REQ || next_state==GAP.
- mem_addr and mem_din keep their last value while idle.
- No reordering and no merging: writes reach SDRAM in arrival order, one request per byte, including duplicate addresses.

Test Plan:
- Single write: after reset, in_wr with addr 0x14000, data 0xA5, mem_ack 3 cycles after req → mem_req rises 2 cycles after in_wr with mem_addr=0x14000, mem_din=0xA5. It drops the cycle after ack; busy then falls; overflow=0.
- Burst to full: DEPTH=4, 4 consecutive in_wr (data 01..04), mem_ack held off → ram_ready falls after the 3rd push and stays low. On acks, SDRAM sees 01,02,03,04 in order with exactly one idle cycle between requests. ram_ready rises once count<=2.
- Overflow: 5 pushes with no ack → the 5th (data 0x55) is never issued and overflow=1 persists after drain; only reset clears it.
- Simultaneous push and pop: FIFO full, in_wr (data 0x99) in the same cycle as mem_ack → no overflow, count stays 4, and 0x99 is issued last.
- Spurious ack: mem_ack pulses in IDLE and in GAP → no pop, pointers unchanged, next real entry still issued correctly.
- Reset mid-operation: 3 entries queued and mem_req high, assert reset for 1 cycle → next cycle mem_req=0, busy=0, ram_ready=1. A late mem_ack afterwards has no effect; a new write after reset is issued normally.

Source files
------------

// File: rtl/snap_ram_writer_if.sv
// SDRAM write-port bus between the snapshot RAM writer (master) and the SDRAM controller (slave).
// mem_req is a level held until the one-cycle mem_ack completion pulse.
interface snap_ram_writer_if #(
    parameter int AW = 25
) ();
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_req;
    logic          mem_ack;

    modport master (
        output mem_addr,
        output mem_din,
        output mem_req,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_din,
        input  mem_req,
        output mem_ack
    );
endinterface

// File: rtl/snap_ram_writer.sv
// Write buffer between the snapshot loader and the shared SDRAM write port: queues byte writes
// in a small FIFO, drains them in order over req/ack, and paces the loader via ram_ready.
module snap_ram_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [AW-1:0]     in_addr,
    input  logic [7:0]        in_data,
    input  logic              in_wr,
    output logic              ram_ready,
    snap_ram_writer_if.master mem,
    output logic              busy,
    output logic              overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_RDY  = (PW+1)'(DEPTH - 2);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q [DEPTH];
    logic [7:0]    data_q [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic [PW:0]   next_count;
    logic          push;
    logic          pop;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted then.
    always_comb begin
        pop        = (state == REQ) && mem.mem_ack;
        push       = in_wr && ((count != CNT_FULL) || pop);
        next_count = count;
        if (push && !pop) begin
            next_count = count + CNT_ONE;
        end else if (pop && !push) begin
            next_count = count - CNT_ONE;
        end
    end

    // The head is copied into mem_addr/mem_din when issued, so overwriting its slot is safe.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            addr_q[wptr] <= in_addr;
            data_q[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            ram_ready    <= 1'b1;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
        end else begin
            count     <= next_count;
            ram_ready <= (next_count <= CNT_RDY);
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (in_wr && !push) begin
                overflow <= 1'b1;
            end

            // GAP holds mem_req low for one edge, then issues exactly like IDLE.
            case (state)
                IDLE, GAP: begin
                    if (count != '0) begin
                        mem.mem_addr <= addr_q[rptr];
                        mem.mem_din  <= data_q[rptr];
                        mem.mem_req  <= 1'b1;
                        state        <= REQ;
                        busy         <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= (next_count != '0);
                    end
                end
                REQ: begin
                    busy <= 1'b1;
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        state       <= GAP;
                    end
                end
                default: begin
                    mem.mem_req <= 1'b0;
                    state       <= IDLE;
                    busy        <= (next_count != '0);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snap_ram_writer.sv
// Directed bench for snap_ram_writer: a queue-based model of pending writes is compared against
// the DUT every cycle, and hand-computed literals pin both the DUT and the model at key points.
module tb_snap_ram_writer;
    localparam int DEPTH = 4;
    localparam int AW    = 25;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [AW-1:0] in_addr;
    logic [7:0]    in_data;
    logic          in_wr;
    logic          ram_ready;
    logic          busy;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    snap_ram_writer_if #(.AW(AW)) mem_bus ();

    snap_ram_writer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_wr     (in_wr),
        .ram_ready (ram_ready),
        .mem       (mem_bus),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Model: a queue of accepted writes. Any cycle without an outstanding request issues the
    // head that was queued at the start of that cycle; an ack retires the head.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } entry_t;

    entry_t        mq[$];
    entry_t        m_entry;
    logic          m_req;
    logic          m_busy;
    logic          m_ready;
    logic          m_ovf;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_din;
    bit            model_valid = 1'b0;
    int            old_size;
    bit            popped;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    always @(posedge clk_sys) begin
        if (reset) begin
            mq.delete();
            m_req       = 1'b0;
            m_addr      = '0;
            m_din       = '0;
            m_busy      = 1'b0;
            m_ready     = 1'b1;
            m_ovf       = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            old_size = mq.size();
            popped   = m_req && (mem_bus.mem_ack === 1'b1);
            if (popped) begin
                void'(mq.pop_front());
                m_req = 1'b0;
            end else if (!m_req && old_size != 0) begin
                m_req  = 1'b1;
                m_addr = mq[0].a;
                m_din  = mq[0].d;
            end
            if (in_wr) begin
                if (old_size < DEPTH || popped) begin
                    m_entry.a = in_addr;
                    m_entry.d = in_data;
                    mq.push_back(m_entry);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_ready = (mq.size() <= DEPTH - 2);
            m_busy  = (mq.size() != 0) || m_req || popped;
        end
    end

    always @(negedge clk_sys) begin
        if (model_valid) begin
            checkOutput("cmp_mem_req", 32'(mem_bus.mem_req), 32'(m_req));
            checkOutput("cmp_mem_addr", 32'(mem_bus.mem_addr), 32'(m_addr));
            checkOutput("cmp_mem_din", 32'(mem_bus.mem_din), 32'(m_din));
            checkOutput("cmp_busy", 32'(busy), 32'(m_busy));
            checkOutput("cmp_ram_ready", 32'(ram_ready), 32'(m_ready));
            checkOutput("cmp_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [7:0] d, input logic ack);
        in_wr           = wr;
        in_addr         = a;
        in_data         = d;
        mem_bus.mem_ack = ack;
        tick();
        in_wr           = 1'b0;
        mem_bus.mem_ack = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic waitReq(input int maxCycles);
        int n = 0;
        while (mem_bus.mem_req !== 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        checks++;
        if (mem_bus.mem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL waitReq: mem_req=%b after %0d cycles, expected 1", mem_bus.mem_req, n);
        end
    endtask

    task automatic drainOne(input logic [7:0] expData, input string tag);
        waitReq(10);
        checkOutput({tag, "_din"}, 32'(mem_bus.mem_din), 32'(expData));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput({tag, "_req_drop"}, 32'(mem_bus.mem_req), 32'd0);
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        in_wr           = 1'b0;
        in_addr         = '0;
        in_data         = '0;
        mem_bus.mem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_ready", 32'(ram_ready), 32'd1);
        checkOutput("rst_req", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        checkOutput("rst_din", 32'(mem_bus.mem_din), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);

        // Single write, acked on the third request cycle
        applyStimulus(1'b1, 25'h14000, 8'hA5, 1'b0);
        checkOutput("s1_busy_early", 32'(busy), 32'd1);
        checkOutput("s1_req_early", 32'(mem_bus.mem_req), 32'd0);
        tick();
        checkOutput("s1_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("s1_addr", 32'(mem_bus.mem_addr), 32'h14000);
        checkOutput("s1_din", 32'(mem_bus.mem_din), 32'hA5);
        checkOutput("pin_m_addr", 32'(m_addr), 32'h14000);
        tick();
        tick();
        checkOutput("s1_req_held", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("s1_addr_held", 32'(mem_bus.mem_addr), 32'h14000);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("s1_req_drop", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("s1_busy_gap", 32'(busy), 32'd1);
        tick();
        checkOutput("s1_busy_end", 32'(busy), 32'd0);
        checkOutput("s1_ovf", 32'(overflow), 32'd0);
        checkOutput("pin_m_busy", 32'(m_busy), 32'd0);

        // Burst to full, then drain with one idle cycle between requests
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, AW'(25'h100 + i), 8'(i + 1), 1'b0);
            if (i == 1) checkOutput("s2_ready_after2", 32'(ram_ready), 32'd1);
            if (i == 2) checkOutput("s2_ready_after3", 32'(ram_ready), 32'd0);
        end
        checkOutput("s2_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("s2_ready_full", 32'(ram_ready), 32'd0);
        tick();
        checkOutput("s2_ready_stays", 32'(ram_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) checkOutput("s2_back2back", 32'(mem_bus.mem_req), 32'd1);
            drainOne(8'(i + 1), "s2");
            if (i == 0) checkOutput("s2_ready_cnt3", 32'(ram_ready), 32'd0);
            if (i == 1) checkOutput("s2_ready_cnt2", 32'(ram_ready), 32'd1);
        end
        checkOutput("s2_busy_done", 32'(busy), 32'd0);

        // Overflow: fifth write into a full FIFO is dropped and the flag is sticky
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, AW'(25'h200 + i), 8'(8'h11 * (i + 1)), 1'b0);
        end
        checkOutput("s3_ovf", 32'(overflow), 32'd1);
        checkOutput("s3_ready", 32'(ram_ready), 32'd0);
        checkOutput("pin_m_qsize_full", 32'(mq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drainOne(8'(8'h11 * (i + 1)), "s3");
        end
        repeat (5) tick();
        checkOutput("s3_no_fifth", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("s3_ovf_sticky", 32'(overflow), 32'd1);
        checkOutput("s3_busy", 32'(busy), 32'd0);
        pulseReset();
        checkOutput("s3_ovf_cleared", 32'(overflow), 32'd0);

        // Push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, AW'(25'h300 + i), 8'(8'h61 + i), 1'b0);
        end
        checkOutput("s4_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("s4_din", 32'(mem_bus.mem_din), 32'h61);
        applyStimulus(1'b1, 25'h3FF, 8'h99, 1'b1);
        checkOutput("s4_ovf", 32'(overflow), 32'd0);
        checkOutput("s4_req_drop", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("s4_ready", 32'(ram_ready), 32'd0);
        checkOutput("pin_m_qsize", 32'(mq.size()), 32'd4);
        drainOne(8'h62, "s4");
        drainOne(8'h63, "s4");
        drainOne(8'h64, "s4");
        drainOne(8'h99, "s4");
        checkOutput("s4_busy", 32'(busy), 32'd0);
        checkOutput("s4_ovf_end", 32'(overflow), 32'd0);

        // Spurious acks in IDLE and in GAP
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("s5_idle_req", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("s5_idle_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 25'h1ABCD, 8'h77, 1'b0);
        applyStimulus(1'b1, 25'h1ABCE, 8'h78, 1'b0);
        checkOutput("s5_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("s5_addr", 32'(mem_bus.mem_addr), 32'h1ABCD);
        checkOutput("s5_din", 32'(mem_bus.mem_din), 32'h77);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("s5_gap_req", 32'(mem_bus.mem_req), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("s5_req2", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("s5_addr2", 32'(mem_bus.mem_addr), 32'h1ABCE);
        checkOutput("s5_din2", 32'(mem_bus.mem_din), 32'h78);
        drainOne(8'h78, "s5");
        checkOutput("s5_busy", 32'(busy), 32'd0);

        // Reset with a request outstanding and entries queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, AW'(25'h400 + i), 8'(8'h81 + i), 1'b0);
        end
        checkOutput("s6_req_before", 32'(mem_bus.mem_req), 32'd1);
        pulseReset();
        checkOutput("s6_req", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("s6_busy", 32'(busy), 32'd0);
        checkOutput("s6_ready", 32'(ram_ready), 32'd1);
        checkOutput("s6_addr", 32'(mem_bus.mem_addr), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("s6_late_ack_req", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("s6_late_ack_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("s6_still_idle", 32'(mem_bus.mem_req), 32'd0);
        applyStimulus(1'b1, 25'h00ABC, 8'hC3, 1'b0);
        tick();
        checkOutput("s6_new_req", 32'(mem_bus.mem_req), 32'd1);
        checkOutput("s6_new_addr", 32'(mem_bus.mem_addr), 32'h00ABC);
        checkOutput("s6_new_din", 32'(mem_bus.mem_din), 32'hC3);
        drainOne(8'hC3, "s6");
        checkOutput("s6_busy_end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
